// File: rtl/wallace_seq_mult_ctrl_if.sv
// ---------------------------------------------------------------------------
// wallace_seq_mult_ctrl_if
// Handshake bundle between a requester and the sequential carry-save
// multiplier controller.
//   in_valid / in_ready / in_a / in_b  : operand request channel
//   out_valid / out_ready / out_product: product response channel
//   busy                               : controller is reducing/resolving
// master = requester/consumer side, slave = controller side.
// ---------------------------------------------------------------------------
interface wallace_seq_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_product, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_product, busy
    );
endinterface

// File: rtl/wallace_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// wallace_seq_mult_ctrl
// Unsigned WIDTH x WIDTH multiplier that reuses one 3:2 carry-save level:
// one partial-product row is folded into the (S, C) pair per cycle, then a
// single carry-propagate add resolves the product.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : wallace_seq_mult_ctrl_if.slave (operand/product handshakes, busy)
// Latency is data-independent: accept, WIDTH reduce cycles, resolve, done.
// ---------------------------------------------------------------------------

// One-bit full adder; a row of these forms the carry-save reduction level.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

module wallace_seq_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    wallace_seq_mult_ctrl_if.slave     bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REDUCE  = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]     s_q, s_d;
    logic [PW-1:0]     c_q, c_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     p_q, p_d;

    // Current partial-product row: A gated by multiplier bit B[cnt],
    // zero-extended and aligned to its row weight.
    logic              row_bit;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     fa_s;
    logic [PW-1:0]     fa_c;

    assign row_bit = |(b_q & (WIDTH'(1) << cnt_q));
    assign pp      = {{WIDTH{1'b0}}, a_q & {WIDTH{row_bit}}} << cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_csa
            full_adder u_fa (
                .a_i   (s_q[gi]),
                .b_i   (c_q[gi]),
                .cin_i (pp[gi]),
                .sum_o (fa_s[gi]),
                .cout_o(fa_c[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                s_d   = fa_s;
                // Carry moves up one weight; the top carry falls off and is
                // always zero since the true product fits in PW bits.
                c_d   = fa_c << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = RESOLVE;
            end
            RESOLVE: begin
                p_d     = s_q + c_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode state only, so there is no combinational
    // path from in_valid/out_ready back to the requester.
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.busy        = (state_q == REDUCE) || (state_q == RESOLVE);
    assign bus.out_product = p_q;
endmodule
